// File: rtl/vmx_issue_seq.sv
// Vector MAC issue sequencer: accepts one command, streams weight words
// (Wget) then multiplicand words (compute) to the PE controller, then
// issues DRAIN_CYCLES rest cycles to flush the PE chain and pulses done.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_mode, cmd_wlen, cmd_xlen
//   x_valid/x_ready       operand handshake; x_data signed operand word
//   ISout, Xout           registered instruction/operand to PE controller
//   busy, done            status; done is a one-cycle pulse on drain exit
//   stall_cnt             bubble-cycle counter
//
// Optional feature macro: VMX_SEQ_STALL_CNT_EN builds the bubble counter;
// when undefined, stall_cnt is tied to zero.
module vmx_issue_seq #(
  parameter int DRAIN_CYCLES = 4,
  parameter int LEN_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [LEN_W-1:0] cmd_wlen,
  input  logic [LEN_W-1:0] cmd_xlen,
  input  logic             x_valid,
  input  logic [15:0]      x_data,
  output logic             x_ready,
  output logic [1:0]       ISout,
  output logic [15:0]      Xout,
  output logic             busy,
  output logic             done,
  output logic [15:0]      stall_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WLOAD   = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] wrem;
  logic [LEN_W-1:0] xrem;
  logic [LEN_W-1:0] xeff;
  logic [1:0]       mode_q;
  logic [DW-1:0]    dcnt;
  logic             started;
  logic             accept;
  logic             fire;
  logic             bubble;
  logic             drain_end;

  // Non-compute modes carry no multiplicands.
  assign xeff      = cmd_mode[1] ? cmd_xlen : '0;
  assign accept    = cmd_valid && cmd_ready;
  assign fire      = x_valid && x_ready;
  assign bubble    = x_ready && !x_valid;
  assign drain_end = (state == DRAIN) && (dcnt == DW'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_wlen != '0)  state_nxt = WLOAD;
          else if (xeff != '0) state_nxt = COMPUTE;
          else                 state_nxt = DRAIN;
        end
      end
      WLOAD: begin
        if (fire && wrem == LEN_W'(1))
          state_nxt = (xrem != '0) ? COMPUTE : DRAIN;
      end
      COMPUTE: begin
        if (fire && xrem == LEN_W'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // started holds cmd_ready low on the reset edge itself, so the
  // command port opens on the first edge after release.
  always_comb begin
    cmd_ready = 1'b0;
    x_ready   = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = started;
      end
      WLOAD:   x_ready = (wrem != '0);
      COMPUTE: x_ready = (xrem != '0);
      DRAIN:   x_ready = 1'b0;
      default: busy    = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      started <= 1'b0;
      mode_q  <= '0;
      wrem    <= '0;
      xrem    <= '0;
      dcnt    <= '0;
      done    <= 1'b0;
    end else begin
      started <= 1'b1;
      done    <= drain_end;
      if (accept) begin
        mode_q <= cmd_mode;
        wrem   <= cmd_wlen;
        xrem   <= xeff;
      end else if (fire) begin
        if (state == WLOAD) wrem <= wrem - LEN_W'(1);
        else                xrem <= xrem - LEN_W'(1);
      end
      if (state == DRAIN && !drain_end) dcnt <= dcnt + DW'(1);
      else                              dcnt <= '0;
    end
  end

  // Issue register: accepted word goes out one cycle later, otherwise rest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ISout <= 2'b00;
      Xout  <= '0;
    end else if (fire) begin
      ISout <= (state == WLOAD) ? 2'b01 : mode_q;
      Xout  <= x_data;
    end else begin
      ISout <= 2'b00;
      Xout  <= '0;
    end
  end

`ifdef VMX_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_q <= '0;
    else if (accept)
      stall_q <= '0;
    else if (bubble && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
  assign stall_cnt     = '0;
`endif

endmodule

// File: tb/tb_vmx_issue_seq.sv
// Directed bench for vmx_issue_seq: issue sequences, bubbles, drain,
// mode skip, busy hold-off, max length and mid-command reset.
module tb_vmx_issue_seq;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [7:0]  cmd_wlen;
  logic [7:0]  cmd_xlen;
  logic        x_valid;
  logic [15:0] x_data;
  logic        x_ready;
  logic [1:0]  ISout;
  logic [15:0] Xout;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  int checks = 0;
  int fails  = 0;

  logic [1:0] exp_is [0:15];

  vmx_issue_seq #(.DRAIN_CYCLES(4), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_wlen  (cmd_wlen),
    .cmd_xlen  (cmd_xlen),
    .x_valid   (x_valid),
    .x_data    (x_data),
    .x_ready   (x_ready),
    .ISout     (ISout),
    .Xout      (Xout),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Interval 0 offers the command; intervals 1..done_at follow the accept.
  task automatic run(input string nm, input logic [1:0] m,
                     input logic [7:0] w, input logic [7:0] x,
                     input logic [15:0] vm, input int xr_end,
                     input int done_at);
    logic [15:0] prev;
    prev      = '0;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_wlen  = w;
    cmd_xlen  = x;
    x_valid   = 1'b0;
    chk({nm, "_rdy"}, 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= done_at; k++) begin
      x_valid = vm[k];
      x_data  = 16'h8000 | (16'(k) * 16'h0101);
      chk($sformatf("%s_is%0d", nm, k), 32'(ISout), 32'(exp_is[k]));
      chk($sformatf("%s_x%0d", nm, k), 32'(Xout),
          (exp_is[k] != 2'b00) ? 32'(prev) : 32'd0);
      chk($sformatf("%s_done%0d", nm, k), 32'(done), 32'(k == done_at));
      chk($sformatf("%s_busy%0d", nm, k), 32'(busy), 32'(k < done_at));
      chk($sformatf("%s_xr%0d", nm, k), 32'(x_ready), 32'(k < xr_end));
      prev = x_data;
      step();
    end
    x_valid = 1'b0;
    chk({nm, "_pulse"}, 32'(done), 32'd0);
    chk({nm, "_idle"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int n;
    int nxr;
    int nis;
    logic seen;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    cmd_wlen  = '0;
    cmd_xlen  = '0;
    x_valid   = 1'b0;
    x_data    = '0;

    step();
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_is", 32'(ISout), 32'd0);
    chk("rst_x", 32'(Xout), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_xr", 32'(x_ready), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // 16-bit mode, 2 weights then 3 multiplicands, no bubbles.
    exp_is = '{0, 0, 1, 1, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run("t16", 2'b10, 8'd2, 8'd3, 16'hFFFF, 6, 10);
    chk("t16_stall", 32'(stall_cnt), 32'd0);

    // 8-bit mode with two bubbles in the middle of compute.
    exp_is = '{0, 0, 1, 3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run("bub", 2'b11, 8'd1, 8'd2, 16'hFFE7, 6, 10);
`ifdef VMX_SEQ_STALL_CNT_EN
    chk("bub_stall", 32'(stall_cnt), 32'd2);
`else
    chk("bub_stall", 32'(stall_cnt), 32'd0);
`endif

    // Empty command: drain only, done 5 cycles after accept.
    exp_is = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run("empty", 2'b10, 8'd0, 8'd0, 16'hFFFF, 1, 5);

    // Non-compute mode: one Wget, compute skipped.
    exp_is = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run("skip", 2'b01, 8'd1, 8'd5, 16'hFFFF, 2, 6);

    // Command held high while busy is accepted on the first idle cycle.
    cmd_valid = 1'b1;
    cmd_mode  = 2'b10;
    cmd_wlen  = '0;
    cmd_xlen  = '0;
    step();
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("hold_rdy%0d", k), 32'(cmd_ready), 32'd0);
      step();
    end
    chk("hold_rdy5", 32'(cmd_ready), 32'd1);
    chk("hold_done5", 32'(done), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("hold_rebusy", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk("hold_done2", 32'(done), 32'd1);
    step();

    // Max weight length issues exactly 255 words.
    cmd_valid = 1'b1;
    cmd_mode  = 2'b00;
    cmd_wlen  = 8'hFF;
    cmd_xlen  = 8'd0;
    x_valid   = 1'b1;
    step();
    cmd_valid = 1'b0;
    n   = 0;
    nxr = 0;
    nis = 0;
    while (!done && n < 400) begin
      if (x_ready) nxr++;
      if (ISout == 2'b01) nis++;
      step();
      n++;
    end
    chk("max_done", 32'(done), 32'd1);
    chk("max_accepts", 32'(nxr), 32'd255);
    chk("max_issued", 32'(nis), 32'd255);
    x_valid = 1'b0;
    step();

    // Reset in compute with two words left abandons the command.
    cmd_valid = 1'b1;
    cmd_mode  = 2'b10;
    cmd_wlen  = 8'd1;
    cmd_xlen  = 8'd4;
    step();
    cmd_valid = 1'b0;
    x_valid   = 1'b1;
    step();
    step();
    step();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_xr", 32'(x_ready), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_is", 32'(ISout), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_xr", 32'(x_ready), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    step();
    chk("mrst_rdy", 32'(cmd_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (done || x_ready || ISout != 2'b00) seen = 1'b1;
      step();
    end
    chk("mrst_quiet", 32'(seen), 32'd0);
    x_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
